ad_spike_aer_out: RTL and testbench

Downstream output stage for the AD-model neuron update logic. It takes the three per-update spike flags produced for one neuron (full, 1/2 and 3/4 threshold levels), encodes each asserted flag as an AER word tagged with the neuron address and level, and buffers the words in a small FIFO. It then drives them off-chip over a 4-phase REQ/ACK AER handshake. Back-pressure to the neuron update controller goes through BUSY. Updates that arrive while the stage is busy are dropped and counted.

---
 rtl/ad_spike_aer_out.sv | 137 +++++++++++++
 tb/tb_ad_spike_aer_out.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad_spike_aer_out.sv
// ad_spike_aer_out: turns the spike flags of one neuron update into AER words, buffers them in a FIFO
// and sends them off-chip over a 4-phase REQ/ACK handshake.
// Optional feature: define AD_MULTILEVEL_EN for three-level encoding. When it is undefined, only
// the full-threshold flag is captured.
module ad_spike_aer_out #(
    parameter int N_ADDR     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              NEUR_UPD_VALID,
    input  logic [N_ADDR-1:0] NEUR_ADDR,
    input  logic [6:0]        EVENT_OUT1,
    input  logic [6:0]        EVENT_OUT2,
    input  logic [6:0]        EVENT_OUT3,
    output logic              BUSY,
    output logic [N_ADDR+1:0] AEROUT_ADDR,
    output logic              AEROUT_REQ,
    input  logic              AEROUT_ACK,
    output logic [7:0]        DROP_CNT
);
`ifdef AD_MULTILEVEL_EN
    localparam int NL = 3;
`else
    localparam int NL = 1;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = N_ADDR + 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_ACKLOW = 2'd2;

    logic [NL-1:0]     flags, mask, sel;
    logic [1:0]        code;
    logic [N_ADDR-1:0] stage_addr;
    logic [W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [1:0]        state;
    logic              ack_s1, ack_s, full, empty, pop, push, hit, capture, drop, unused_bits;

`ifdef AD_MULTILEVEL_EN
    // mask bit 2 = full (11), bit 1 = 3/4 (10), bit 0 = 1/2 (01); highest bit is emitted first
    assign unused_bits = ^{EVENT_OUT1[5:0], EVENT_OUT2[5:0], EVENT_OUT3[5:0]};
    assign flags       = {EVENT_OUT1[6], EVENT_OUT3[6], EVENT_OUT2[6]};
    assign sel         = mask[2] ? 3'b100 : mask[1] ? 3'b010 : {2'b00, mask[0]};
    assign code        = mask[2] ? 2'b11 : mask[1] ? 2'b10 : 2'b01;
`else
    assign unused_bits = ^{EVENT_OUT1[5:0], EVENT_OUT2, EVENT_OUT3};
    assign flags       = EVENT_OUT1[6];
    assign sel         = mask;
    assign code        = 2'b11;
`endif

    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign hit     = NEUR_UPD_VALID && |flags;
    assign capture = hit && mask == '0;
    assign drop    = hit && |mask;
    assign pop     = state == S_IDLE && !empty;
    // a pop on the same edge frees the slot, so a full FIFO can still accept a word
    assign push    = |mask && (!full || pop);
    assign BUSY    = |mask;

    // staging register: load on capture, clear one bit per accepted push
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mask       <= '0;
            stage_addr <= '0;
        end else if (capture) begin
            mask       <= flags;
            stage_addr <= NEUR_ADDR;
        end else if (push) begin
            mask <= mask & ~sel;
        end
    end

    // saturating count of updates refused while the staging register was occupied
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            DROP_CNT <= '0;
        else if (drop && DROP_CNT != 8'hFF)
            DROP_CNT <= DROP_CNT + 8'd1;
    end

    // FIFO storage; no reset needed since occupancy is tracked by count
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {code, stage_addr};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // two-flop synchronizer for the off-chip acknowledge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= AEROUT_ACK;
            ack_s  <= ack_s1;
        end
    end

    // 4-phase handshake; the address is held from REQ rise until the return to idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            AEROUT_REQ  <= 1'b0;
            AEROUT_ADDR <= '0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    AEROUT_ADDR <= mem[rd_ptr];
                    AEROUT_REQ  <= 1'b1;
                    state       <= S_REQ;
                end
                S_REQ: if (ack_s) begin
                    AEROUT_REQ <= 1'b0;
                    state      <= S_ACKLOW;
                end
                default: if (!ack_s) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad_spike_aer_out.sv
// tb_ad_spike_aer_out: queue-based reference model compared every cycle, plus literal scenario checks
module tb_ad_spike_aer_out;
    localparam int D = 8;
`ifdef AD_MULTILEVEL_EN
    localparam bit ML = 1'b1;
`else
    localparam bit ML = 1'b0;
`endif
    logic       clk = 0, rst = 0, valid = 0, ack = 0;
    logic [7:0] addr = 0;
    logic [6:0] e1 = 0, e2 = 0, e3 = 0;
    logic       busy, req;
    logic [9:0] aer;
    logic [7:0] drop;
    int         checks = 0, errors = 0;
    bit         ack_en = 1;
    int         ack_dly = 2;

    always #5 clk = ~clk;

    ad_spike_aer_out #(.N_ADDR(8), .FIFO_DEPTH(D)) dut (
        .CLK(clk), .RST(rst), .NEUR_UPD_VALID(valid), .NEUR_ADDR(addr),
        .EVENT_OUT1(e1), .EVENT_OUT2(e2), .EVENT_OUT3(e3), .BUSY(busy),
        .AEROUT_ADDR(aer), .AEROUT_REQ(req), .AEROUT_ACK(ack), .DROP_CNT(drop));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // reference model: pending words per update, FIFO contents and handshake phase as queues/ints
    logic [9:0] m_fifo[$], m_stage[$];
    int         m_phase = 0, m_drop = 0;
    bit         m_s1 = 0, m_s = 0, m_req = 0;
    logic [9:0] m_addr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete(); m_stage.delete();
            m_phase = 0; m_drop = 0; m_s1 = 0; m_s = 0; m_req = 0; m_addr = 0;
        end else begin
            bit pop, push, f1, f2, f3, any;
            pop  = m_phase == 0 && m_fifo.size() > 0;
            push = m_stage.size() > 0 && (m_fifo.size() < D || pop);
            f1 = e1[6]; f2 = ML && e2[6]; f3 = ML && e3[6];
            any = f1 | f2 | f3;
            if (valid && any && m_stage.size() > 0 && m_drop < 255) m_drop++;
            case (m_phase)
                0: if (pop) begin m_addr = m_fifo.pop_front(); m_req = 1; m_phase = 1; end
                1: if (m_s) begin m_req = 0; m_phase = 2; end
                default: if (!m_s) m_phase = 0;
            endcase
            if (push) m_fifo.push_back(m_stage.pop_front());
            else if (valid && any && m_stage.size() == 0) begin
                if (f1) m_stage.push_back({2'b11, addr});
                if (f3) m_stage.push_back({2'b10, addr});
                if (f2) m_stage.push_back({2'b01, addr});
            end
            m_s  = m_s1;
            m_s1 = ack;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, m_stage.size() > 0);
            chk("req", req, m_req);
            chk("aer_addr", aer, m_addr);
            chk("drop_cnt", drop, m_drop);
        end
    end

    // log of words seen at each REQ rise
    logic [9:0] log_q[$], exp_q[$];
    bit prev_req = 0;
    always @(negedge clk) begin
        if (req && !prev_req) log_q.push_back(aer);
        prev_req = req;
    end

    // off-chip receiver: raises ACK ack_dly cycles after REQ, drops it ack_dly cycles after REQ falls
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin ack = 0; c = 0; end
            else if (req && !ack) begin
                if (ack_en) begin c++; if (c >= ack_dly) begin ack = 1; c = 0; end end
            end else if (!req && ack) begin
                c++; if (c >= ack_dly) begin ack = 0; c = 0; end
            end else c = 0;
        end
    end

    task automatic upd(input logic [7:0] a, input bit f1, input bit f2, input bit f3);
        @(posedge clk); #1;
        valid = 1; addr = a;
        e1 = {f1, 6'($urandom)}; e2 = {f2, 6'($urandom)}; e3 = {f3, 6'($urandom)};
        @(posedge clk); #1;
        valid = 0; e1 = 0; e2 = 0; e3 = 0;
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while (!(m_stage.size() == 0 && m_fifo.size() == 0 && m_phase == 0 && !ack && !req) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= budget) begin errors++; $display("FAIL quiet_timeout actual=%0d expected<%0d", n, budget); end
    endtask

    task automatic check_log(input string n);
        chk({n, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_w%0d", n, i), log_q[i], exp_q[i]);
    endtask

    function automatic void exp_upd(input logic [7:0] a, input bit f1, input bit f2, input bit f3);
        if (f1) exp_q.push_back({2'b11, a});
        if (ML && f3) exp_q.push_back({2'b10, a});
        if (ML && f2) exp_q.push_back({2'b01, a});
    endfunction

    initial begin
        int lat, bc, n, nupd;
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_req", req, 0); chk("rst_busy", busy, 0); chk("rst_aer", aer, 0); chk("rst_drop", drop, 0);
        rst = 0;

        // three flags at 0x2A
        wait_quiet(100);
        log_q.delete(); exp_q.delete();
        upd(8'h2A, 1, 1, 1);
        bc = 0;
        for (int i = 0; i < 6; i++) begin if (busy) bc++; @(posedge clk); #1; end
`ifdef AD_MULTILEVEL_EN
        chk("busy_cycles3", bc, 3);
        exp_q.push_back(10'h32A); exp_q.push_back(10'h22A); exp_q.push_back(10'h12A);
`else
        chk("busy_cycles1", bc, 1);
        exp_q.push_back(10'h32A);
`endif
        wait_quiet(200);
        check_log("all3");

        // 1/2-threshold only at 0x05
        log_q.delete(); exp_q.delete();
        upd(8'h05, 0, 1, 0);
        lat = 0;
`ifdef AD_MULTILEVEL_EN
        while (!req && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("req_latency", lat, 2);
        exp_q.push_back(10'h105);
`endif
        wait_quiet(200);
        check_log("flag2");

        // one drop, then saturation with ACK withheld
        chk("drop_pre", drop, 0);
        @(posedge clk); #1 valid = 1; addr = 8'h33; e1 = 7'h40; e2 = 7'h40; e3 = 7'h40;
        @(posedge clk); #1 addr = 8'h44;
        @(posedge clk); #1 valid = 0; e1 = 0; e2 = 0; e3 = 0;
        chk("drop_one", drop, 1);
        ack_en = 0;
        valid = 1; e1 = 7'h40; e2 = 7'h40; e3 = 7'h40;
        repeat (320) @(posedge clk);
        #1 valid = 0; e1 = 0; e2 = 0; e3 = 0;
        chk("drop_sat", drop, 255);
        chk("req_held", req, 1);

        // asynchronous reset mid-handshake
        @(posedge clk); #3 rst = 1;
        #1;
        chk("arst_req", req, 0); chk("arst_busy", busy, 0); chk("arst_aer", aer, 0); chk("arst_drop", drop, 0);
        @(posedge clk); #3 rst = 0;

        // fill FIFO with ACK low, then drain
        log_q.delete(); exp_q.delete();
        nupd = ML ? 4 : 10;
        for (int i = 0; i < nupd; i++) begin
            n = 0;
            while (busy && n < 100) begin @(posedge clk); #1; n++; end
            checks++;
            if (n >= 100) begin errors++; $display("FAIL fill_busy_timeout actual=%0d expected<100", n); end
            upd(8'(8'h80 + i), 1, 1, 1);
            exp_upd(8'(8'h80 + i), 1, 1, 1);
        end
        repeat (20) @(posedge clk);
        #1;
        chk("fill_busy", busy, 1);
        chk("fill_words_out", log_q.size(), 1);
        ack_en = 1;
        wait_quiet(800);
        check_log("drain");

        // flags 1 and 2 at 0x10
        log_q.delete(); exp_q.delete();
        upd(8'h10, 1, 1, 0);
`ifdef AD_MULTILEVEL_EN
        exp_q.push_back(10'h310); exp_q.push_back(10'h110);
`else
        exp_q.push_back(10'h310);
`endif
        wait_quiet(200);
        check_log("f12");
        chk("f12_drop", drop, 0);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            ack_en = (c % 300) < 220;
            if (c % 50 == 0) ack_dly = $urandom_range(1, 5);
            valid = $urandom_range(0, 2) == 0;
            addr = 8'($urandom);
            e1 = 7'($urandom); e2 = 7'($urandom); e3 = 7'($urandom);
        end
        #1 valid = 0; e1 = 0; e2 = 0; e3 = 0; ack_en = 1;
        wait_quiet(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
